control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 24 ++
 rtl/control_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: control-unit <-> datapath bundle.
// master (control unit): drives all bus-source selects, load enables, select/encode
//   controls, memory strobes and Run; samples IR, CON and Stop.
// slave (datapath): the mirror image.
interface control_unit_if;
  logic [31:0] IR;
  logic CON, Stop;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
  logic PCIn, IRIn, MARIn, MDRIn, YIn, ZIn, HiIn, LoIn, OutIn, IncPC;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic read, write, Run;
  modport master (
    input  IR, CON, Stop,
    output PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
           PCIn, IRIn, MARIn, MDRIn, YIn, ZIn, HiIn, LoIn, OutIn, IncPC,
           Gra, Grb, Grc, Rin, Rout, BAout, read, write, Run
  );
  modport slave (
    output IR, CON, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
           PCIn, IRIn, MARIn, MDRIn, YIn, ZIn, HiIn, LoIn, OutIn, IncPC,
           Gra, Grb, Grc, Rin, Rout, BAout, read, write, Run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch and execute (RESET, T0-T7, HALT).
// Ports: clk rising-edge clock; clr synchronous active-low reset;
//   bus (control_unit_if.master) carries IR/CON/Stop in and all control strobes out.
// Define CU_MULDIV_EN to add mul (01111) and div (10000); otherwise they act as nop.
module control_unit (
  input logic clk,
  input logic clr,
  control_unit_if.master bus
);
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  state_t state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic flag_q, flag_d;
  logic alu, imm, ldi, ld, st, br, jr, inp, outp, mfhi, mflo, halt, md, short_op, last;
  logic t0, t1, t2, t3, t4, t5, t6, t7;
  logic unused;
  assign unused = ^bus.IR[26:0];
  assign alu  = opcode_q inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
  assign imm  = opcode_q inside {5'b01100, 5'b01101, 5'b01110};
  assign ldi  = opcode_q == 5'b00001;
  assign ld   = opcode_q == 5'b00000;
  assign st   = opcode_q == 5'b00010;
  assign br   = opcode_q == 5'b10010;
  assign jr   = opcode_q == 5'b10011;
  assign inp  = opcode_q == 5'b10101;
  assign outp = opcode_q == 5'b10110;
  assign mfhi = opcode_q == 5'b10111;
  assign mflo = opcode_q == 5'b11000;
  assign halt = opcode_q == 5'b11010;
`ifdef CU_MULDIV_EN
  assign md   = opcode_q inside {5'b01111, 5'b10000};
`else
  assign md   = 1'b0;
`endif
  // Everything that is not a multi-step instruction (nop, unknown, single-step) ends in T3.
  assign short_op = !(alu | imm | ldi | ld | st | br | md | halt);
  assign {t0, t1, t2, t3, t4, t5, t6, t7} = {state_q == T0, state_q == T1, state_q == T2,
    state_q == T3, state_q == T4, state_q == T5, state_q == T6, state_q == T7};
  assign last = (t3 & short_op) | (t5 & (alu | imm | ldi)) | (t6 & (br | md)) | t7;
  always_comb begin
    state_d  = state_q == RESET ? T0 :
               state_q == HALT ? HALT :
               (t3 & halt) ? HALT :
               last ? (bus.Stop ? HALT : T0) :
               state_t'(state_q + 4'd1);
    opcode_d = t2 ? bus.IR[31:27] : opcode_q;
    flag_d   = (t3 & br) ? bus.CON : flag_q;
  end
  always_comb begin
    bus.PCout      = t0 | (t4 & br);
    bus.Zlowout    = t1 | (t5 & (alu | imm | ldi | ld | st | md)) | (t6 & br & flag_q);
    bus.Zhighout   = t6 & md;
    bus.MDRout     = t2 | (t7 & ld);
    bus.Cout       = (t4 & (imm | ldi | ld | st)) | (t5 & br);
    bus.In_Portout = t3 & inp;
    bus.LOout      = t3 & mflo;
    bus.HIout      = t3 & mfhi;
    bus.PCIn       = t1 | (t3 & jr) | (t6 & br & flag_q);
    bus.IRIn       = t2;
    bus.MARIn      = t0 | (t5 & (ld | st));
    bus.MDRIn      = t1 | (t6 & (ld | st));
    bus.YIn        = (t3 & (alu | imm | ldi | ld | st | md)) | (t4 & br);
    bus.ZIn        = t0 | (t4 & (alu | imm | ldi | ld | st | md)) | (t5 & br);
    bus.HiIn       = t6 & md;
    bus.LoIn       = t5 & md;
    bus.OutIn      = t3 & outp;
    bus.IncPC      = t0;
    bus.Gra        = (t3 & (br | jr | inp | outp | mfhi | mflo | md)) | (t5 & (alu | imm | ldi)) |
                     (t6 & st) | (t7 & ld);
    bus.Grb        = (t3 & (alu | imm | ldi | ld | st)) | (t4 & md);
    bus.Grc        = t4 & alu;
    bus.Rin        = (t3 & (inp | mfhi | mflo)) | (t5 & (alu | imm | ldi)) | (t7 & ld);
    bus.Rout       = (t3 & (alu | imm | br | jr | outp | md)) | (t4 & (alu | md)) | (t6 & st);
    bus.BAout      = t3 & (ldi | ld | st);
    bus.read       = t1 | (t6 & ld);
    bus.write      = t7 & st;
    bus.Run        = state_q != RESET && state_q != HALT;
  end
  always_ff @(posedge clk)
    if (!clr) begin
      state_q  <= RESET;
      opcode_q <= 5'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      flag_q   <= flag_d;
    end
endmodule
